relu_pool: RTL and testbench

Post-accumulation stage of the convolution datapath. It consumes one finished 34-bit dot product per output pixel from the multiply-accumulate stage, sampled when that stage pulses its completion flag. For each pixel it adds the channel bias, applies ReLU and rescales back to 17-bit Q12.4 with rounding and saturation. It then performs 2x2/stride-2 max pooling over the raster-ordered conv output map and emits pooled pixels to the next layer's input buffer.

---
 rtl/lenet_pkg.sv | 34 +++
 rtl/pool_line_buffer.sv | 33 +++
 rtl/relu_pool.sv | 160 ++++++++++++++++
 tb/tb_relu_pool.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared LeNet datapath definitions: Q-format constants, the saturation limit,
// the pixel/sum types and the ReLU + round + saturate helper used by the
// convolution post-stage and the fully-connected stage.
package lenet_pkg;

    localparam int unsigned Bitwidth  = 17;              // Q12.4 feature width
    localparam int unsigned AccWidth  = 2 * Bitwidth;    // Q24.8 accumulator
    localparam int unsigned FracBits  = 4;
    localparam int unsigned SumWidth  = AccWidth + 1;    // bias add cannot overflow

    // Largest positive Q12.4 value, 2^(Bitwidth-1)-1.
    localparam logic [Bitwidth-1:0] SatMax = {1'b0, {(Bitwidth-1){1'b1}}};

    // Half an output LSB, expressed in accumulator units.
    localparam logic [SumWidth-1:0] RoundHalf =
        {{(SumWidth-FracBits){1'b0}}, 1'b1, {(FracBits-1){1'b0}}};

    typedef logic [Bitwidth-1:0]        pixel_t;
    typedef logic signed [SumWidth-1:0] sum_t;

    // ReLU, then round-half-up from Q24.8 down to Q12.4, then clamp to SatMax.
    function automatic pixel_t relu_round_sat(input sum_t sum);
        logic [SumWidth-1:0] r;
        if (sum[SumWidth-1]) begin
            return '0;
        end
        r = ($unsigned(sum) + RoundHalf) >> FracBits;
        if (r > SumWidth'(SatMax)) begin
            return SatMax;
        end
        return r[Bitwidth-1:0];
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Line buffer holding the horizontal pair maxima of an even conv row until the
// following odd row pools against them.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write index (pooled column)
//   wdata_i : value to store
//   raddr_i : read index (pooled column)
//   rdata_o : combinational read data
module pool_line_buffer #(
    parameter int unsigned Depth = 14,
    parameter int unsigned Width = 17,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    // Contents are not reset: every entry is rewritten by an even row before use.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/relu_pool.sv
// Convolution post-stage: bias add, ReLU with rounding/saturation to Q12.4, then
// 2x2 stride-2 max pooling over the raster-ordered conv output map.
//   clk        : clock
//   reset      : asynchronous active-high reset
//   in_valid   : one-cycle pulse, in_data holds a finished dot product
//   in_data    : signed Q24.8 dot product
//   bias       : signed Q12.4 channel bias, stable for a frame
//   out_valid  : one-cycle pulse, out_data is a pooled pixel
//   out_data   : pooled pixel, Q12.4, never negative
//   out_row    : pooled row index
//   out_col    : pooled column index
//   frame_done : pulses with the last out_valid of a frame
module relu_pool
    import lenet_pkg::*;
#(
    parameter int unsigned bitwidth   = Bitwidth,
    parameter int unsigned acc_width  = AccWidth,
    parameter int unsigned frac_bits  = FracBits,
    parameter int unsigned out_width  = 28,
    parameter int unsigned out_height = 28
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    input  logic [acc_width-1:0]              in_data,
    input  logic [bitwidth-1:0]               bias,
    output logic                              out_valid,
    output logic [bitwidth-1:0]               out_data,
    output logic [$clog2(out_height/2)-1:0]   out_row,
    output logic [$clog2(out_width/2)-1:0]    out_col,
    output logic                              frame_done
);

    localparam int unsigned ColW    = $clog2(out_width);
    localparam int unsigned RowW    = $clog2(out_height);
    localparam int unsigned OutColW = $clog2(out_width/2);
    localparam int unsigned OutRowW = $clog2(out_height/2);

    if ((out_width % 2) != 0 || (out_height % 2) != 0) begin : gen_bad_dims
        $error("relu_pool: out_width and out_height must both be even");
    end
    if (bitwidth != Bitwidth || acc_width != AccWidth || frac_bits != FracBits) begin : gen_bad_fmt
        $error("relu_pool: Q-format parameters must match lenet_pkg");
    end

    // S1: bias add
    sum_t s1_sum_d, s1_sum_q;
    logic s1_valid_q;

    assign s1_sum_d = sum_t'($signed(in_data)) + (sum_t'($signed(bias)) <<< frac_bits);

    // S2: ReLU / rescale
    pixel_t s2_pix_q;
    logic   s2_valid_q;

    // S3: pooling
    logic [ColW-1:0]    col_q, col_d;
    logic [RowW-1:0]    row_q, row_d;
    pixel_t             hmax_q, hmax_d;
    pixel_t             pair, lb_rdata;
    logic               lb_we;
    logic [OutColW-1:0] lb_addr;
    logic               last_col, last_row;

    logic               out_valid_q, out_valid_d;
    pixel_t             out_data_q, out_data_d;
    logic [OutRowW-1:0] out_row_q, out_row_d;
    logic [OutColW-1:0] out_col_q, out_col_d;
    logic               frame_done_q, frame_done_d;

    assign last_col = (col_q == ColW'(out_width - 1));
    assign last_row = (row_q == RowW'(out_height - 1));
    assign lb_addr  = col_q[ColW-1:1];
    assign pair     = (s2_pix_q > hmax_q) ? s2_pix_q : hmax_q;

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hmax_d       = hmax_q;
        lb_we        = 1'b0;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        frame_done_d = 1'b0;
        if (s2_valid_q) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RowW'(1);
            end else begin
                col_d = col_q + ColW'(1);
            end
            if (!col_q[0]) begin
                hmax_d = s2_pix_q;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                out_valid_d  = 1'b1;
                out_data_d   = (lb_rdata > pair) ? lb_rdata : pair;
                out_row_d    = row_q[RowW-1:1];
                out_col_d    = col_q[ColW-1:1];
                frame_done_d = last_col && last_row;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_sum_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_pix_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            hmax_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sum_q <= s1_sum_d;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_pix_q <= relu_round_sat(s1_sum_q);
            end
            col_q        <= col_d;
            row_q        <= row_d;
            hmax_q       <= hmax_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Same index for read and write: even rows only write, odd rows only read.
    pool_line_buffer #(
        .Depth (out_width / 2),
        .Width (Bitwidth)
    ) u_line_buffer (
        .clk_i   (clk),
        .we_i    (lb_we),
        .waddr_i (lb_addr),
        .wdata_i (pair),
        .raddr_i (lb_addr),
        .rdata_o (lb_rdata)
    );

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_pool.sv
// Directed bench for relu_pool: a 4x4 instance checks values, positions, latency,
// frame wrap and mid-frame reset; a 28x28 instance checks a back-to-back stream.
module tb_relu_pool;

    localparam logic [33:0] Neg   = 34'h3_FFFF_FF00;   // -0x100
    localparam logic [33:0] Big30 = 34'h0_4000_0000;   // 2^30

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid4, in_valid28;
    logic [33:0] in_data;
    logic [16:0] bias, cur_bias;

    logic        o4_valid, o4_done;
    logic [16:0] o4_data;
    logic [0:0]  o4_row, o4_col;
    logic        o28_valid, o28_done;
    logic [16:0] o28_data;
    logic [3:0]  o28_row, o28_col;

    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    int unsigned cnt28 = 0, done28 = 0, cnt_at_done1 = 0;

    typedef struct {
        int unsigned cyc;
        logic [16:0] data;
        int unsigned row;
        int unsigned col;
        bit          done;
    } exp_t;
    exp_t exp_q[$];

    logic [33:0] fpx [16];
    logic [16:0] fexp [4];

    relu_pool #(.out_width(4), .out_height(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_data(in_data), .bias(bias),
        .out_valid(o4_valid), .out_data(o4_data), .out_row(o4_row), .out_col(o4_col),
        .frame_done(o4_done)
    );

    relu_pool #(.out_width(28), .out_height(28)) dut28 (
        .clk(clk), .reset(reset), .in_valid(in_valid28), .in_data(in_data), .bias(bias),
        .out_valid(o28_valid), .out_data(o28_data), .out_row(o28_row), .out_col(o28_col),
        .frame_done(o28_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid4  = 1'b0;
            in_valid28 = 1'b0;
        end
    endtask

    task automatic send_px(input logic [33:0] d, input bit ev, input logic [16:0] ed,
                           input int er, input int ec, input bit edone);
        exp_t e;
        @(negedge clk);
        in_valid4 = 1'b1;
        in_data   = d;
        bias      = cur_bias;
        if (ev) begin
            e.cyc  = cyc + 3;
            e.data = ed;
            e.row  = er;
            e.col  = ec;
            e.done = edone;
            exp_q.push_back(e);
        end
    endtask

    task automatic run_frame(input logic [16:0] b, input int gap, input int npix,
                             input bit drop_last);
        cur_bias = b;
        for (int i = 0; i < npix; i++) begin
            int r, c;
            bit ev;
            r  = i / 4;
            c  = i % 4;
            ev = r[0] && c[0] && !(drop_last && i == npix - 1);
            send_px(fpx[i], ev, fexp[(r / 2) * 2 + c / 2], r / 2, c / 2, i == 15);
            if (gap != 0) idle(gap);
        end
    endtask

    task automatic fill_neg();
        for (int i = 0; i < 16; i++) fpx[i] = Neg;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 16; i++) fpx[i] = 34'(i + 1) << 8;
        fexp[0] = 17'h60; fexp[1] = 17'h80; fexp[2] = 17'hE0; fexp[3] = 17'h100;
    endtask

    // 4x4 scoreboard: data, position, frame_done and arrival cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            check("out4_missing", 64'(0), 64'(1));
            exp_q.delete(0);
        end
        if (o4_valid) begin
            if (exp_q.size() == 0) begin
                check("out4_spurious", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("out4_cycle", 64'(cyc), 64'(e.cyc));
                check("out4_data", 64'(o4_data), 64'(e.data));
                check("out4_row", 64'(o4_row), 64'(e.row));
                check("out4_col", 64'(o4_col), 64'(e.col));
                check("out4_done", 64'(o4_done), 64'(e.done));
            end
        end else if (o4_done) begin
            check("out4_done_alone", 64'(1), 64'(0));
        end
    end

    // 28x28 monitor: pooled max is the bottom-right pixel of each block
    always @(negedge clk) begin
        int n, r, c;
        if (o28_valid) begin
            n = cnt28 % 196;
            r = n / 14;
            c = n % 14;
            check("out28_row", 64'(o28_row), 64'(r));
            check("out28_col", 64'(o28_col), 64'(c));
            check("out28_data", 64'(o28_data), 64'(((2 * r + 1) * 28 + 2 * c + 1) * 16));
            check("out28_done", 64'(o28_done), 64'(n == 195));
            cnt28++;
            if (o28_done) begin
                done28++;
                if (done28 == 1) cnt_at_done1 = cnt28;
            end
        end else if (o28_done) begin
            check("out28_done_alone", 64'(1), 64'(0));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        in_valid4  = 1'b0;
        in_valid28 = 1'b0;
        in_data    = '0;
        bias       = '0;
        cur_bias   = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(o4_valid), 64'(0));
        check("rst_out_data", 64'(o4_data), 64'(0));
        check("rst_out_row", 64'(o4_row), 64'(0));
        check("rst_out_col", 64'(o4_col), 64'(0));
        check("rst_frame_done", 64'(o4_done), 64'(0));
        check("rst_out28_valid", 64'(o28_valid), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", 64'(o4_valid), 64'(0));

        // Frame A, bias +1.0: rescale 0x640 -> 0x74, sum 0 -> 0, rounding 0x1F8 -> 0x20
        fill_neg();
        fpx[0] = 34'h640; fpx[7] = 34'h0F8; fpx[8] = 34'h640; fpx[13] = 34'h700;
        fpx[14] = 34'h3_FFFF_FEFF; fpx[15] = 34'h3_FFFF_FEF7;
        fexp[0] = 17'h74; fexp[1] = 17'h20; fexp[2] = 17'h80; fexp[3] = 17'h0;
        run_frame(17'h00010, 0, 16, 1'b0);

        // Frame C, bias 0: saturation boundaries, follows A with no idle cycle
        fill_neg();
        fpx[0] = Big30; fpx[1] = Big30; fpx[4] = Big30; fpx[5] = Big30;
        fpx[2] = 34'h10_0000; fpx[9] = 34'hF_FE00; fpx[12] = 34'hF_FD00;
        fpx[15] = 34'hF_FFF8; fpx[10] = 34'hF_FFF7;
        fexp[0] = 17'hFFFF; fexp[1] = 17'hFFFF; fexp[2] = 17'hFFE0; fexp[3] = 17'hFFFF;
        run_frame(17'h00000, 0, 16, 1'b0);

        // Frame D, bias 0x0FFFF with 2^30 everywhere: saturate, no wrap
        for (int i = 0; i < 16; i++) fpx[i] = Big30;
        for (int i = 0; i < 4; i++) fexp[i] = 17'hFFFF;
        run_frame(17'h0FFFF, 0, 16, 1'b0);

        // Frame E, bias -1.0: bias must be sign-extended
        fill_neg();
        fpx[5] = 34'h640; fpx[3] = 34'h100; fpx[2] = 34'h10F; fpx[12] = 34'h1_0000;
        fpx[10] = 34'h200;
        fexp[0] = 17'h54; fexp[1] = 17'h1; fexp[2] = 17'hFF0; fexp[3] = 17'h10;
        run_frame(17'h1FFF0, 0, 16, 1'b0);

        // Frame B, bias 0, with idle gaps: ReLU of -0x100, rounding of small values
        fill_neg();
        fpx[1] = 34'h18; fpx[6] = 34'h08; fpx[7] = 34'h07; fpx[14] = 34'h17; fpx[11] = 34'h28;
        fexp[0] = 17'h2; fexp[1] = 17'h1; fexp[2] = 17'h0; fexp[3] = 17'h3;
        run_frame(17'h00000, 2, 16, 1'b0);
        idle(3);

        // Ramp 1..16: clean frame, then 30-pixel stream aborted by reset, then fresh frame
        fill_ramp();
        run_frame(17'h00000, 0, 16, 1'b0);
        idle(4);
        run_frame(17'h00000, 0, 16, 1'b0);
        run_frame(17'h00000, 0, 14, 1'b1);
        @(negedge clk);
        in_valid4 = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(o4_valid), 64'(0));
        reset = 1'b0;
        run_frame(17'h00000, 0, 16, 1'b0);
        idle(8);
        check("out4_all_seen", 64'(exp_q.size()), 64'(0));

        // Two back-to-back 28x28 frames
        bias = '0;
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < 784; p++) begin
                @(negedge clk);
                in_valid28 = 1'b1;
                in_data    = 34'(p) << 8;
            end
        end
        idle(8);
        check("f28_total_outputs", 64'(cnt28), 64'(392));
        check("f28_frame_done_count", 64'(done28), 64'(2));
        check("f28_outputs_first_frame", 64'(cnt_at_done1), 64'(196));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
